// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: ID-stage operand/destination info and the
// control outputs returned to the pipeline registers and forward muxes.
// Handshake semantics: there is no valid/ready pair on this bus. ID-stage
// fields are qualified by id_valid and sampled every rising clock edge
// unless mem_wait is high. The controls are level signals, valid in the
// same cycle as their inputs. The forward selects are registered and
// belong to the instruction currently in EX.
interface hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = 2
);
  logic                  mem_wait;
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_use_rs;
  logic                  id_use_rt;
  logic                  id_wr_en;
  logic [REG_ADDR_W-1:0] id_wr_addr;
  logic                  id_is_load;
  logic                  ex_branch_taken;
  logic [SEL_W-1:0]      fwd_a_sel;
  logic [SEL_W-1:0]      fwd_b_sel;
  logic                  stall;
  logic                  bubble_ex;
  logic                  flush_id;

  // Pipeline side: drives the ID info and receives the controls.
  modport master (
    output mem_wait, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_wr_en, id_wr_addr, id_is_load, ex_branch_taken,
    input  fwd_a_sel, fwd_b_sel, stall, bubble_ex, flush_id
  );

  // Hazard controller side.
  modport slave (
    input  mem_wait, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_wr_en, id_wr_addr, id_is_load, ex_branch_taken,
    output fwd_a_sel, fwd_b_sel, stall, bubble_ex, flush_id
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core.
// It keeps a two-entry scoreboard that tracks the destinations of the
// instructions in EX and MEM. It produces registered forward selects and
// combinational stall, bubble and flush controls.
// Optional macro HAZARD_STATS_EN adds the stall_cnt and flush_cnt counters.
module hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = 2
) (
  input  logic         clk,
  input  logic         rst,
`ifdef HAZARD_STATS_EN
  output logic [31:0]  stall_cnt,
  output logic [31:0]  flush_cnt,
`endif
  hazard_ctrl_if.slave bus
);

  localparam logic [SEL_W-1:0] SEL_RAW = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_EX  = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_MEM = SEL_W'(2);

  // Scoreboard slots. The MEM slot needs no load flag: a load that has
  // reached MEM can be forwarded from MEM/WB.
  logic                  r_ex_v;
  logic                  r_ex_wr;
  logic [REG_ADDR_W-1:0] r_ex_addr;
  logic                  r_ex_ld;
  logic                  r_mem_v;
  logic                  r_mem_wr;
  logic [REG_ADDR_W-1:0] r_mem_addr;
  logic [SEL_W-1:0]      r_fwd_a;
  logic [SEL_W-1:0]      r_fwd_b;

  logic                  w_ex_hit_rs;
  logic                  w_ex_hit_rt;
  logic                  w_mem_hit_rs;
  logic                  w_mem_hit_rt;
  logic                  w_luh;
  logic                  w_stall;
  logic                  w_bubble;
  logic                  w_flush;
  logic [SEL_W-1:0]      w_fwd_a;
  logic [SEL_W-1:0]      w_fwd_b;

  // Slot match terms. Register $0 never matches.
  always_comb begin
    w_ex_hit_rs  = r_ex_v  && r_ex_wr  && (r_ex_addr  == bus.id_rs) && (bus.id_rs != '0);
    w_ex_hit_rt  = r_ex_v  && r_ex_wr  && (r_ex_addr  == bus.id_rt) && (bus.id_rt != '0);
    w_mem_hit_rs = r_mem_v && r_mem_wr && (r_mem_addr == bus.id_rs) && (bus.id_rs != '0);
    w_mem_hit_rt = r_mem_v && r_mem_wr && (r_mem_addr == bus.id_rt) && (bus.id_rt != '0);
  end

  // Load-use detection. The load flag is enough here because a load always
  // writes its destination.
  always_comb begin
    w_luh = bus.id_valid && r_ex_v && r_ex_ld && (r_ex_addr != '0) &&
            ((bus.id_use_rs && (r_ex_addr == bus.id_rs)) ||
             (bus.id_use_rt && (r_ex_addr == bus.id_rt)));
  end

  // Controls. A taken branch overrides a load-use stall. Reset and a memory
  // freeze both force every control low.
  always_comb begin
    w_stall  = 1'b0;
    w_bubble = 1'b0;
    w_flush  = 1'b0;
    if (!rst && !bus.mem_wait) begin
      if (bus.ex_branch_taken) begin
        w_flush  = 1'b1;
        w_bubble = 1'b1;
      end else if (w_luh) begin
        w_stall  = 1'b1;
        w_bubble = 1'b1;
      end
    end
  end

  // Forward selects for the ID instruction. A match in EX wins over a match
  // in MEM because EX holds the younger writer.
  always_comb begin
    w_fwd_a = SEL_RAW;
    w_fwd_b = SEL_RAW;
    if (bus.id_use_rs) begin
      if (w_ex_hit_rs)       w_fwd_a = SEL_EX;
      else if (w_mem_hit_rs) w_fwd_a = SEL_MEM;
    end
    if (bus.id_use_rt) begin
      if (w_ex_hit_rt)       w_fwd_b = SEL_EX;
      else if (w_mem_hit_rt) w_fwd_b = SEL_MEM;
    end
  end

  // Scoreboard and select registers advance with the pipeline. They hold
  // while the memory system freezes the core.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_v     <= 1'b0;
      r_ex_wr    <= 1'b0;
      r_ex_addr  <= '0;
      r_ex_ld    <= 1'b0;
      r_mem_v    <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_mem_addr <= '0;
      r_fwd_a    <= SEL_RAW;
      r_fwd_b    <= SEL_RAW;
    end else if (!bus.mem_wait) begin
      r_mem_v    <= r_ex_v;
      r_mem_wr   <= r_ex_wr;
      r_mem_addr <= r_ex_addr;
      if (w_bubble) begin
        r_ex_v  <= 1'b0;
        r_ex_wr <= 1'b0;
        r_ex_ld <= 1'b0;
        r_fwd_a <= SEL_RAW;
        r_fwd_b <= SEL_RAW;
      end else begin
        r_ex_v    <= bus.id_valid;
        r_ex_wr   <= bus.id_wr_en;
        r_ex_addr <= bus.id_wr_addr;
        r_ex_ld   <= bus.id_is_load;
        r_fwd_a   <= w_fwd_a;
        r_fwd_b   <= w_fwd_b;
      end
    end
  end

  assign bus.fwd_a_sel = r_fwd_a;
  assign bus.fwd_b_sel = r_fwd_b;
  assign bus.stall     = w_stall;
  assign bus.bubble_ex = w_bubble;
  assign bus.flush_id  = w_flush;

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Event counters. They wrap naturally. Controls are already low during a
  // freeze, so each counted cycle is one that really advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_flush) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule
